// File: rtl/instr_fetcher_pkg.sv
// Shared configuration for the instruction fetch stage: FSM state encodings
// and the default PC reset value and address width.
// Optional build macro FETCHER_STATS_EN adds the stall_cycles counter port
// to instr_fetcher. Uncomment the line below, or pass +define+ on the tool
// command line, to enable it.
// `define FETCHER_STATS_EN

package instr_fetcher_pkg;

  // Fetch FSM state encodings
  typedef enum logic [1:0] {
    FETCH_ST_IDLE  = 2'b00,
    FETCH_ST_WAIT  = 2'b01,
    FETCH_ST_HOLD  = 2'b10,
    FETCH_ST_DRAIN = 2'b11
  } fetch_state_e;

  // Default PC / request address width
  localparam int unsigned FETCH_ADDR_WIDTH = 32;

  // Default PC loaded on reset
  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

  // Instruction word width
  localparam int unsigned FETCH_INSTR_WIDTH = 32;

  // Width of the optional stall counter
  localparam int unsigned FETCH_STALL_WIDTH = 32;

endpackage

// File: rtl/instr_fetcher.sv
// Single-outstanding instruction fetch stage feeding the decoder.
// Holds the PC, issues one word request at a time to the instruction cache,
// holds the returned word for the decoder until issued, then follows the
// decoder's predicted PC. A RoB flush (clear) redirects the PC; a request
// already accepted by the cache when the flush hits is drained and discarded.
//
// Ports:
//   clk, rst              clock (rising edge), async active-low reset
//   rdy                   global enable; low freezes every register
//   icache_req_*          request handshake to the cache (valid/addr are
//                         decoded directly from state/pc)
//   icache_resp_*         one-cycle response strobe and data
//   instr_ready/instr_out/instr_addr_out  word and its PC to the decoder
//   predict_pc            decoder's predicted next PC for instr_out
//   instr_issued          decoder consumed instr_out this cycle
//   clear, clear_pc       misprediction flush and redirect target
//   stall_cycles          only with FETCHER_STATS_EN: saturating count of
//                         rdy cycles spent stalled in HOLD or draining

module instr_fetcher
  import instr_fetcher_pkg::*;
#(
  parameter int unsigned             ADDR_WIDTH = FETCH_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0]   RESET_PC   = ADDR_WIDTH'(FETCH_RESET_PC)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rdy,
  output logic                         icache_req_valid,
  input  logic                         icache_req_ready,
  output logic [ADDR_WIDTH-1:0]        icache_req_addr,
  input  logic                         icache_resp_valid,
  input  logic [FETCH_INSTR_WIDTH-1:0] icache_resp_data,
  output logic                         instr_ready,
  output logic [FETCH_INSTR_WIDTH-1:0] instr_out,
  output logic [ADDR_WIDTH-1:0]        instr_addr_out,
  input  logic [ADDR_WIDTH-1:0]        predict_pc,
  input  logic                         instr_issued,
  input  logic                         clear,
  input  logic [ADDR_WIDTH-1:0]        clear_pc
`ifdef FETCHER_STATS_EN
  ,
  output logic [FETCH_STALL_WIDTH-1:0] stall_cycles
`endif
);

  // Clears the two byte-offset bits so every PC is word aligned
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

  fetch_state_e          state;
  logic [ADDR_WIDTH-1:0] pc;

  // Request is presented whenever idle; address is the live PC
  assign icache_req_valid = (state == FETCH_ST_IDLE);
  assign icache_req_addr  = pc;

  // Fetch FSM with registered decoder-facing outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= FETCH_ST_IDLE;
      pc             <= RESET_PC & ALIGN_MASK;
      instr_ready    <= 1'b0;
      instr_out      <= '0;
      instr_addr_out <= '0;
    end else if (rdy) begin
      if (clear) begin
        // Flush wins over everything; a request the cache has already
        // accepted (or is accepting now) must have its response drained.
        pc          <= clear_pc & ALIGN_MASK;
        instr_ready <= 1'b0;
        case (state)
          FETCH_ST_IDLE:  state <= icache_req_ready  ? FETCH_ST_DRAIN : FETCH_ST_IDLE;
          FETCH_ST_WAIT:  state <= icache_resp_valid ? FETCH_ST_IDLE  : FETCH_ST_DRAIN;
          FETCH_ST_HOLD:  state <= FETCH_ST_IDLE;
          FETCH_ST_DRAIN: state <= icache_resp_valid ? FETCH_ST_IDLE  : FETCH_ST_DRAIN;
          default:        state <= FETCH_ST_IDLE;
        endcase
      end else begin
        case (state)
          FETCH_ST_IDLE: begin
            if (icache_req_ready) begin
              state <= FETCH_ST_WAIT;
            end
          end
          FETCH_ST_WAIT: begin
            if (icache_resp_valid) begin
              instr_out      <= icache_resp_data;
              instr_addr_out <= pc;
              instr_ready    <= 1'b1;
              state          <= FETCH_ST_HOLD;
            end
          end
          FETCH_ST_HOLD: begin
            if (instr_issued) begin
              pc          <= predict_pc & ALIGN_MASK;
              instr_ready <= 1'b0;
              state       <= FETCH_ST_IDLE;
            end
          end
          FETCH_ST_DRAIN: begin
            // Stale response from a flushed request is discarded
            if (icache_resp_valid) begin
              state <= FETCH_ST_IDLE;
            end
          end
          default: state <= FETCH_ST_IDLE;
        endcase
      end
    end
  end

`ifdef FETCHER_STATS_EN
  logic stall_now;

  // Stalled: holding a word the decoder has not taken, or draining
  assign stall_now = ((state == FETCH_ST_HOLD) && !instr_issued) ||
                     (state == FETCH_ST_DRAIN);

  // Saturating stall counter; only reset clears it, flushes do not
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
    end else if (rdy && stall_now && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + FETCH_STALL_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetcher.sv
// Bench for instr_fetcher: a per-cycle vector table drives the fetch stage
// and checks the request and decoder-facing outputs, while a scoreboard
// queue tracks each response that should reach the decoder and is checked
// when instr_ready rises. Ends with an asynchronous reset in mid-run.
`timescale 1ns/1ps

module tb_instr_fetcher;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        icache_req_valid;
  logic        icache_req_ready;
  logic [31:0] icache_req_addr;
  logic        icache_resp_valid;
  logic [31:0] icache_resp_data;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [31:0] instr_addr_out;
  logic [31:0] predict_pc;
  logic        instr_issued;
  logic        clear;
  logic [31:0] clear_pc;
`ifdef FETCHER_STATS_EN
  logic [31:0] stall_cycles;
`endif

  instr_fetcher #(
    .ADDR_WIDTH(32),
    .RESET_PC  (32'h0000_0000)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .rdy              (rdy),
    .icache_req_valid (icache_req_valid),
    .icache_req_ready (icache_req_ready),
    .icache_req_addr  (icache_req_addr),
    .icache_resp_valid(icache_resp_valid),
    .icache_resp_data (icache_resp_data),
    .instr_ready      (instr_ready),
    .instr_out        (instr_out),
    .instr_addr_out   (instr_addr_out),
    .predict_pc       (predict_pc),
    .instr_issued     (instr_issued),
    .clear            (clear),
    .clear_pc         (clear_pc)
`ifdef FETCHER_STATS_EN
    ,
    .stall_cycles     (stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        rq;
    logic        rsp;
    logic [31:0] data;
    logic [31:0] pred;
    logic        iss;
    logic        clr;
    logic [31:0] cpc;
    logic        push;
    logic        e_rv;
    logic [31:0] e_ra;
    logic        e_ir;
    logic [31:0] e_io;
    logic [31:0] e_ia;
    logic [31:0] e_st;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [31:0] addr;
  } sb_t;

  localparam int NV = 31;
  vec_t vecs [NV];
  sb_t  sb_q [$];

  int checks = 0;
  int errors = 0;
  int cyc    = -1;
  int pops   = 0;
  logic mon_en  = 1'b0;
  logic ir_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %h want %h", name, cyc, act, exp);
    end
  endtask

  function automatic vec_t v(input logic r, input logic rq, input logic rsp,
                             input logic [31:0] data, input logic [31:0] pred,
                             input logic iss, input logic clr, input logic [31:0] cpc,
                             input logic push, input logic e_rv, input logic [31:0] e_ra,
                             input logic e_ir, input logic [31:0] e_io,
                             input logic [31:0] e_ia, input logic [31:0] e_st);
    vec_t t;
    t.rdy = r;   t.rq = rq;     t.rsp = rsp;   t.data = data; t.pred = pred;
    t.iss = iss; t.clr = clr;   t.cpc = cpc;   t.push = push;
    t.e_rv = e_rv; t.e_ra = e_ra; t.e_ir = e_ir; t.e_io = e_io; t.e_ia = e_ia;
    t.e_st = e_st;
    return t;
  endfunction

  // Scoreboard: each accepted response must surface when instr_ready rises
  always @(negedge clk) begin
    if (mon_en) begin
      if (instr_ready && !ir_prev) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_ready", 32'(instr_ready), 32'(0));
        end else begin
          sb_t e;
          e = sb_q.pop_front();
          pops++;
          chk("sb_instr_out", instr_out, e.data);
          chk("sb_instr_addr", instr_addr_out, e.addr);
        end
      end
      ir_prev = instr_ready;
    end
  end

  initial begin
    // rdy,rq,rsp,data,pred,iss,clr,cpc,push | rv,ra,ir,io,ia,stall
    vecs[0]  = v(1,1,0,0,0,0,0,0,0,                          1,32'h0,0,32'h0,32'h0,0);
    vecs[1]  = v(1,0,0,0,0,0,0,0,0,                          0,32'h0,0,32'h0,32'h0,0);
    vecs[2]  = v(1,0,1,32'h0000_0513,0,0,0,0,1,              0,32'h0,0,32'h0,32'h0,0);
    vecs[3]  = v(1,0,0,0,0,0,0,0,0,                          0,32'h0,1,32'h513,32'h0,0);
    vecs[4]  = v(1,0,0,0,0,0,0,0,0,                          0,32'h0,1,32'h513,32'h0,1);
    vecs[5]  = v(1,0,0,0,0,0,0,0,0,                          0,32'h0,1,32'h513,32'h0,2);
    vecs[6]  = v(1,0,0,0,32'h4,1,0,0,0,                      0,32'h0,1,32'h513,32'h0,3);
    vecs[7]  = v(1,1,0,0,0,0,0,0,0,                          1,32'h4,0,32'h513,32'h0,3);
    vecs[8]  = v(1,0,0,0,0,0,1,32'h100,0,                    0,32'h0,0,32'h513,32'h0,3);
    vecs[9]  = v(1,0,0,0,0,0,0,0,0,                          0,32'h0,0,32'h513,32'h0,3);
    vecs[10] = v(1,0,1,32'hDEAD_BEEF,0,0,0,0,0,              0,32'h0,0,32'h513,32'h0,4);
    vecs[11] = v(1,1,0,0,0,0,0,0,0,                          1,32'h100,0,32'h513,32'h0,5);
    vecs[12] = v(1,0,1,32'h0000_0BAD,0,0,1,32'h1FF,0,        0,32'h0,0,32'h513,32'h0,5);
    vecs[13] = v(1,1,0,0,0,0,0,0,0,                          1,32'h1FC,0,32'h513,32'h0,5);
    vecs[14] = v(1,0,1,32'h00A0_0093,0,0,0,0,1,              0,32'h0,0,32'h513,32'h0,5);
    vecs[15] = v(1,0,0,0,32'h8,1,1,32'h200,0,                0,32'h0,1,32'h00A0_0093,32'h1FC,5);
    vecs[16] = v(1,1,0,0,0,0,1,32'h300,0,                    1,32'h200,0,32'h00A0_0093,32'h1FC,5);
    vecs[17] = v(1,0,0,0,0,0,1,32'h304,0,                    0,32'h0,0,32'h00A0_0093,32'h1FC,5);
    vecs[18] = v(1,0,1,32'hFFFF_FFFF,0,0,0,0,0,              0,32'h0,0,32'h00A0_0093,32'h1FC,6);
    vecs[19] = v(1,0,1,32'h55,32'h800,1,0,0,0,               1,32'h304,0,32'h00A0_0093,32'h1FC,7);
    vecs[20] = v(1,1,0,0,0,0,0,0,0,                          1,32'h304,0,32'h00A0_0093,32'h1FC,7);
    vecs[21] = v(1,0,1,32'h1234_5678,0,0,0,0,1,              0,32'h0,0,32'h00A0_0093,32'h1FC,7);
    for (int i = 22; i < 27; i++)
      vecs[i] = v(0,0,0,0,32'h400,1,0,0,0,                   0,32'h0,1,32'h1234_5678,32'h304,7);
    vecs[27] = v(1,0,0,0,0,0,0,0,0,                          0,32'h0,1,32'h1234_5678,32'h304,7);
    vecs[28] = v(1,0,0,0,32'hFFFF_FFFF,1,0,0,0,              0,32'h0,1,32'h1234_5678,32'h304,8);
    vecs[29] = v(0,1,0,0,0,0,0,0,0,                          1,32'hFFFF_FFFC,0,32'h1234_5678,32'h304,8);
    vecs[30] = v(1,0,0,0,0,0,0,0,0,                          1,32'hFFFF_FFFC,0,32'h1234_5678,32'h304,8);

    rst = 1'b0; rdy = 1'b1;
    icache_req_ready = 1'b0; icache_resp_valid = 1'b0; icache_resp_data = '0;
    predict_pc = '0; instr_issued = 1'b0; clear = 1'b0; clear_pc = '0;

    // Reset state
    @(negedge clk);
    chk("rst_req_valid", 32'(icache_req_valid), 32'(1));
    chk("rst_req_addr", icache_req_addr, 32'h0);
    chk("rst_instr_ready", 32'(instr_ready), 32'(0));
    chk("rst_instr_out", instr_out, 32'h0);
    chk("rst_instr_addr", instr_addr_out, 32'h0);
`ifdef FETCHER_STATS_EN
    chk("rst_stall", stall_cycles, 32'h0);
`endif
    rst = 1'b1;
    mon_en = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      cyc = i;
      chk("req_valid", 32'(icache_req_valid), 32'(vecs[i].e_rv));
      if (vecs[i].e_rv) chk("req_addr", icache_req_addr, vecs[i].e_ra);
      chk("instr_ready", 32'(instr_ready), 32'(vecs[i].e_ir));
      chk("instr_out", instr_out, vecs[i].e_io);
      chk("instr_addr", instr_addr_out, vecs[i].e_ia);
`ifdef FETCHER_STATS_EN
      chk("stall_cycles", stall_cycles, vecs[i].e_st);
`endif
      rdy               = vecs[i].rdy;
      icache_req_ready  = vecs[i].rq;
      icache_resp_valid = vecs[i].rsp;
      icache_resp_data  = vecs[i].data;
      predict_pc        = vecs[i].pred;
      instr_issued      = vecs[i].iss;
      clear             = vecs[i].clr;
      clear_pc          = vecs[i].cpc;
      if (vecs[i].push) begin
        sb_t e;
        e.data = vecs[i].data;
        e.addr = vecs[i].e_ra;
        // Address of the pending word is the last accepted request address
        e.addr = (i == 2) ? 32'h0 : (i == 14) ? 32'h1FC : 32'h304;
        sb_q.push_back(e);
      end
    end

    @(negedge clk);
    cyc = NV;
    icache_req_ready = 1'b1; icache_resp_valid = 1'b0; instr_issued = 1'b0;
    clear = 1'b0; rdy = 1'b1;
    chk("sb_pops", 32'(pops), 32'(3));
    chk("sb_empty", 32'(sb_q.size()), 32'(0));

    // Asynchronous reset in mid-cycle, away from any clock edge
    @(posedge clk);
    #2;
    mon_en = 1'b0;
    rst = 1'b0;
    #1;
    cyc = NV + 1;
    chk("arst_req_valid", 32'(icache_req_valid), 32'(1));
    chk("arst_req_addr", icache_req_addr, 32'h0);
    chk("arst_instr_ready", 32'(instr_ready), 32'(0));
    chk("arst_instr_out", instr_out, 32'h0);
    chk("arst_instr_addr", instr_addr_out, 32'h0);
`ifdef FETCHER_STATS_EN
    chk("arst_stall", stall_cycles, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #100000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
